// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial pattern detector.
// Takes WIDTH-bit words over a valid/ready handshake and emits them one bit per
// clock on SER_OUT. A one-entry hold register lets the next word be accepted
// while the current one shifts, so with GAP_CYCLES=0 the stream has no bubbles.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SER_OUT,
    output logic             SER_VALID,
    output logic             WORD_DONE,
    output logic             BUSY
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shifter_n;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_n;
    logic             hold_full;
    logic             hold_full_n;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_n;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_cnt_n;
    logic             ser_out_n;
    logic             ser_valid_n;
    logic             word_done_n;
    logic             transfer;

    // Shift the word one position toward the output end, filling with 0.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    // The bit currently presented on the serial line for a given shifter value.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // The hold register is the only back-pressure point; nothing is accepted in reset.
    assign DIN_READY = !hold_full && !RST;
    assign transfer  = DIN_VALID && DIN_READY;
    assign BUSY      = (state != IDLE) || hold_full;

    // Next-state logic: drain the hold register before capturing a new word into it.
    always_comb begin
        state_n     = state;
        shifter_n   = shifter;
        hold_n      = hold;
        hold_full_n = hold_full;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;

        case (state)
            IDLE: begin
                if (transfer) begin
                    shifter_n = DIN;
                    bit_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_n = '0;
                    shifter_n = shift_once(shifter);
                    if (GAP_CYCLES > 0) begin
                        state_n   = GAP;
                        gap_cnt_n = '0;
                        if (transfer) begin
                            hold_n      = DIN;
                            hold_full_n = 1'b1;
                        end
                    end else if (hold_full) begin
                        shifter_n   = hold;
                        hold_full_n = 1'b0;
                        if (transfer) begin
                            hold_n      = DIN;
                            hold_full_n = 1'b1;
                        end
                    end else if (transfer) begin
                        shifter_n = DIN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    shifter_n = shift_once(shifter);
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (transfer) begin
                        hold_n      = DIN;
                        hold_full_n = 1'b1;
                    end
                end
            end

            GAP: begin
                gap_cnt_n = gap_cnt + 8'd1;
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    bit_cnt_n = '0;
                    if (hold_full) begin
                        shifter_n   = hold;
                        hold_full_n = 1'b0;
                        state_n     = SHIFT;
                        if (transfer) begin
                            hold_n      = DIN;
                            hold_full_n = 1'b1;
                        end
                    end else if (transfer) begin
                        shifter_n = DIN;
                        state_n   = SHIFT;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (transfer) begin
                    hold_n      = DIN;
                    hold_full_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        ser_valid_n = (state_n == SHIFT);
        ser_out_n   = ser_valid_n ? lead_bit(shifter_n) : IDLE_LEVEL;
        word_done_n = ser_valid_n && (bit_cnt_n == LAST_BIT);
    end

    // State and registered serial outputs; synchronous reset aborts any word in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            SER_OUT   <= IDLE_LEVEL;
            SER_VALID <= 1'b0;
            WORD_DONE <= 1'b0;
        end else begin
            state     <= state_n;
            shifter   <= shifter_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            SER_OUT   <= ser_out_n;
            SER_VALID <= ser_valid_n;
            WORD_DONE <= word_done_n;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of bit_serializer in three configurations
// (defaults, GAP_CYCLES=3, LSB-first) plus a small 1100 detector fed by the stream.
module tb_bit_serializer;

    logic       CLK;
    logic       RST;

    logic [7:0] d_din;
    logic       d_valid, d_ready, d_ser, d_sv, d_wd, d_busy;
    logic [7:0] g_din;
    logic       g_valid, g_ready, g_ser, g_sv, g_wd, g_busy;
    logic [7:0] l_din;
    logic       l_valid, l_ready, l_ser, l_sv, l_wd, l_busy;

    logic [2:0] det_hist;
    logic       det_out;

    int checks   = 0;
    int failures = 0;

    bit_serializer u_def (
        .CLK(CLK), .RST(RST), .DIN(d_din), .DIN_VALID(d_valid), .DIN_READY(d_ready),
        .SER_OUT(d_ser), .SER_VALID(d_sv), .WORD_DONE(d_wd), .BUSY(d_busy)
    );

    bit_serializer #(.GAP_CYCLES(3)) u_gap (
        .CLK(CLK), .RST(RST), .DIN(g_din), .DIN_VALID(g_valid), .DIN_READY(g_ready),
        .SER_OUT(g_ser), .SER_VALID(g_sv), .WORD_DONE(g_wd), .BUSY(g_busy)
    );

    bit_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .RST(RST), .DIN(l_din), .DIN_VALID(l_valid), .DIN_READY(l_ready),
        .SER_OUT(l_ser), .SER_VALID(l_sv), .WORD_DONE(l_wd), .BUSY(l_busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference 1100 detector: remembers the last three valid bits of the default stream.
    always @(posedge CLK) begin
        if (RST) begin
            det_hist <= 3'b000;
        end else if (d_sv) begin
            det_hist <= {det_hist[1:0], d_ser};
        end
    end

    assign det_out = d_sv && ({det_hist, d_ser} == 4'b1100);

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] din, input logic valid);
        d_din   = din;
        d_valid = valid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        logic [7:0]  w8;
        logic [15:0] w16;

        RST = 1'b1;
        applyStimulus(8'h00, 1'b0);
        g_din = 8'h00; g_valid = 1'b0;
        l_din = 8'h00; l_valid = 1'b0;
        step();
        step();

        // Reset state
        checkOutput("rst_sv", d_sv, 1'b0);
        checkOutput("rst_ser", d_ser, 1'b0);
        checkOutput("rst_wd", d_wd, 1'b0);
        checkOutput("rst_busy", d_busy, 1'b0);
        checkOutput("rst_ready", d_ready, 1'b0);
        RST = 1'b0;
        #1;
        checkOutput("rel_ready", d_ready, 1'b1);

        // T2: single word A4, MSB first
        w8 = 8'b1010_0100;
        applyStimulus(8'hA4, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t2_sv%0d", i), d_sv, 1'b1);
            checkOutput($sformatf("t2_ser%0d", i), d_ser, w8[7-i]);
            checkOutput($sformatf("t2_wd%0d", i), d_wd, (i == 7));
            step();
        end
        checkOutput("t2_end_sv", d_sv, 1'b0);
        checkOutput("t2_end_ser", d_ser, 1'b0);
        checkOutput("t2_end_wd", d_wd, 1'b0);

        // T3: back-to-back 80 then 01 with no gap
        w16 = 16'b1000_0000_0000_0001;
        applyStimulus(8'h80, 1'b1);
        step();
        checkOutput("t3_sv0", d_sv, 1'b1);
        checkOutput("t3_ser0", d_ser, 1'b1);
        checkOutput("t3_ready0", d_ready, 1'b1);
        applyStimulus(8'h01, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        checkOutput("t3_ready1", d_ready, 1'b0);
        for (int k = 1; k < 16; k++) begin
            checkOutput($sformatf("t3_sv%0d", k), d_sv, 1'b1);
            checkOutput($sformatf("t3_ser%0d", k), d_ser, w16[15-k]);
            checkOutput($sformatf("t3_wd%0d", k), d_wd, (k == 7 || k == 15));
            if (k == 7) checkOutput("t3_ready7", d_ready, 1'b0);
            if (k == 8) checkOutput("t3_ready8", d_ready, 1'b1);
            step();
        end
        checkOutput("t3_end_sv", d_sv, 1'b0);
        checkOutput("t3_end_busy", d_busy, 1'b0);

        // T1: reset mid-word with a word waiting in hold
        applyStimulus(8'hFF, 1'b1);
        step();
        applyStimulus(8'h0F, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        step();
        step();
        checkOutput("t1_bit3_sv", d_sv, 1'b1);
        checkOutput("t1_bit3_ser", d_ser, 1'b1);
        checkOutput("t1_hold_busy", d_busy, 1'b1);
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput($sformatf("t1_rst_sv%0d", i), d_sv, 1'b0);
            checkOutput($sformatf("t1_rst_ser%0d", i), d_ser, 1'b0);
            checkOutput($sformatf("t1_rst_wd%0d", i), d_wd, 1'b0);
            checkOutput($sformatf("t1_rst_ready%0d", i), d_ready, 1'b0);
        end
        RST = 1'b0;
        #1;
        checkOutput("t1_rel_ready", d_ready, 1'b1);
        checkOutput("t1_rel_busy", d_busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput($sformatf("t1_after_sv%0d", i), d_sv, 1'b0);
            checkOutput($sformatf("t1_after_wd%0d", i), d_wd, 1'b0);
        end

        // T5: LSB first, then last-bit bypass of the next word
        l_din = 8'h01; l_valid = 1'b1;
        step();
        l_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("t5_sv%0d", k), l_sv, 1'b1);
            checkOutput($sformatf("t5_ser%0d", k), l_ser, (k == 0));
            checkOutput($sformatf("t5_wd%0d", k), l_wd, 1'b0);
            step();
        end
        checkOutput("t5_ser7", l_ser, 1'b0);
        checkOutput("t5_wd7", l_wd, 1'b1);
        checkOutput("t5_ready7", l_ready, 1'b1);
        l_din = 8'h03; l_valid = 1'b1;
        step();
        l_valid = 1'b0;
        checkOutput("t5_byp_sv0", l_sv, 1'b1);
        checkOutput("t5_byp_ser0", l_ser, 1'b1);
        checkOutput("t5_byp_wd0", l_wd, 1'b0);
        step();
        checkOutput("t5_byp_ser1", l_ser, 1'b1);
        step();
        checkOutput("t5_byp_ser2", l_ser, 1'b0);
        repeat (5) step();
        checkOutput("t5_byp_wd7", l_wd, 1'b1);
        step();
        checkOutput("t5_end_sv", l_sv, 1'b0);
        checkOutput("t5_end_busy", l_busy, 1'b0);

        // T4: GAP_CYCLES=3 between two queued words
        g_din = 8'hC3; g_valid = 1'b1;
        step();
        g_din = 8'h5A;
        step();
        g_valid = 1'b0;
        checkOutput("t4_ready1", g_ready, 1'b0);
        for (int k = 1; k < 8; k++) begin
            checkOutput($sformatf("t4_sv%0d", k), g_sv, 1'b1);
            checkOutput($sformatf("t4_wd%0d", k), g_wd, (k == 7));
            step();
        end
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("t4_gap_sv%0d", j), g_sv, 1'b0);
            checkOutput($sformatf("t4_gap_ser%0d", j), g_ser, 1'b0);
            checkOutput($sformatf("t4_gap_busy%0d", j), g_busy, 1'b1);
            step();
        end
        checkOutput("t4_w2_sv0", g_sv, 1'b1);
        checkOutput("t4_w2_ser0", g_ser, 1'b0);
        step();
        checkOutput("t4_w2_ser1", g_ser, 1'b1);
        repeat (6) step();
        checkOutput("t4_w2_wd7", g_wd, 1'b1);
        step();
        checkOutput("t4_tail_busy", g_busy, 1'b1);
        checkOutput("t4_tail_sv", g_sv, 1'b0);
        repeat (3) step();
        checkOutput("t4_idle_busy", g_busy, 1'b0);

        // T6: C0 into the 1100 detector, hit only on bit index 3
        RST = 1'b1;
        step();
        RST = 1'b0;
        applyStimulus(8'b1100_0000, 1'b1);
        step();
        applyStimulus(8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t6_det%0d", k), det_out, (k == 3));
            step();
        end
        checkOutput("t6_det_idle", det_out, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
